ltssm_timer_scheduler: RTL and testbench

//  Owns the single shared LTSSM timeout counter. Arbitrates it between the master RX and master TX

---
 rtl/ltssm_timer_scheduler.sv | 140 ++++++++++++++
 tb/tb_ltssm_timer_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltssm_timer_scheduler.sv
// Single shared LTSSM timeout counter, arbitrated round-robin between the RX and TX masters.
// Each master sees only its own timeout flag; a losing or blocked request is parked as pending.
module ltssm_timer_scheduler #(
  parameter int TICKS_PER_US = 250,
  parameter int US_W         = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rxStartTimer,
  input  logic            rxEnableTimer,
  input  logic [2:0]      rxTimeToWait,
  input  logic            txStartTimer,
  input  logic            txEnableTimer,
  input  logic [2:0]      txTimeToWait,
  output logic            rxTimeOut,
  output logic            txTimeOut,
  output logic            busy,
  output logic            owner,
  output logic [US_W-1:0] elapsedUs
);

  localparam int PRE_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t            state, stateNext;
  logic [PRE_W-1:0]  preCnt, preCntNext;
  logic [US_W-1:0]   elapsedNext;
  logic [US_W-1:0]   limit, limitNext;
  logic              ownerNext;
  logic              lastGrant, lastGrantNext;
  logic              pendingRx, pendingRxNext;
  logic              pendingTx, pendingTxNext;

  logic              rxReq, txReq, rxCand, txCand;
  logic              grantRx, grantTx;
  logic              ownerEn, ownerReq;
  logic [2:0]        ownerCode;
  logic              busyNow;

  function automatic logic [US_W-1:0] decodeWait(input logic [2:0] code);
    case (code)
      3'd1:    return US_W'(12000);
      3'd2:    return US_W'(24000);
      3'd3:    return US_W'(48000);
      3'd4:    return US_W'(2000);
      3'd5:    return US_W'(8000);
      3'd6:    return US_W'(1000);
      default: return '0;
    endcase
  endfunction

  assign rxReq     = rxStartTimer & rxEnableTimer;
  assign txReq     = txStartTimer & txEnableTimer;
  assign rxCand    = rxEnableTimer & (rxStartTimer | pendingRx);
  assign txCand    = txEnableTimer & (txStartTimer | pendingTx);
  assign ownerEn   = owner ? txEnableTimer : rxEnableTimer;
  assign ownerReq  = owner ? txReq : rxReq;
  assign ownerCode = owner ? txTimeToWait : rxTimeToWait;
  assign busyNow   = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      preCnt    <= '0;
      elapsedUs <= '0;
      limit     <= '0;
      owner     <= 1'b0;
      lastGrant <= 1'b1;
      pendingRx <= 1'b0;
      pendingTx <= 1'b0;
    end else begin
      state     <= stateNext;
      preCnt    <= preCntNext;
      elapsedUs <= elapsedNext;
      limit     <= limitNext;
      owner     <= ownerNext;
      lastGrant <= lastGrantNext;
      pendingRx <= pendingRxNext;
      pendingTx <= pendingTxNext;
    end
  end

  always_comb begin
    stateNext     = state;
    preCntNext    = preCnt;
    elapsedNext   = elapsedUs;
    limitNext     = limit;
    ownerNext     = owner;
    lastGrantNext = lastGrant;
    grantRx       = 1'b0;
    grantTx       = 1'b0;
    case (state)
      IDLE: begin
        // On a tie, lastGrant=TX means RX goes next
        grantRx = rxCand & (~txCand | lastGrant);
        grantTx = txCand & (~rxCand | ~lastGrant);
        if (grantRx | grantTx) begin
          stateNext     = RUN;
          ownerNext     = grantTx;
          lastGrantNext = grantTx;
          limitNext     = decodeWait(grantTx ? txTimeToWait : rxTimeToWait);
          preCntNext    = '0;
          elapsedNext   = '0;
        end
      end
      RUN, EXPIRED: begin
        if (!ownerEn) begin
          stateNext = IDLE;
        end else if (ownerReq) begin
          stateNext   = RUN;
          limitNext   = decodeWait(ownerCode);
          preCntNext  = '0;
          elapsedNext = '0;
        end else if (state == RUN) begin
          // Limit compare happens before the count advances, so counters freeze on expiry
          if (elapsedUs == limit) begin
            stateNext = EXPIRED;
          end else if (preCnt == PRE_W'(TICKS_PER_US - 1)) begin
            preCntNext  = '0;
            elapsedNext = elapsedUs + 1'b1;
          end else begin
            preCntNext = preCnt + 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
    // A request that is not the owner's restart and not granted now is parked until enable drops
    pendingRxNext = rxEnableTimer & ~grantRx & (pendingRx | (rxReq & ~(busyNow & ~owner)));
    pendingTxNext = txEnableTimer & ~grantTx & (pendingTx | (txReq & ~(busyNow & owner)));
  end

  always_comb begin
    busy      = busyNow;
    rxTimeOut = (state == EXPIRED) & ~owner;
    txTimeOut = (state == EXPIRED) & owner;
  end

endmodule

// File: tb/tb_ltssm_timer_scheduler.sv
// Randomized and directed bench for ltssm_timer_scheduler against a cycle-count model
// that tracks grants, pending requests and edges-since-grant rather than the counters.
module tb_ltssm_timer_scheduler;
  localparam int T    = 4;
  localparam int US_W = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            rxStartTimer = 1'b0, rxEnableTimer = 1'b0;
  logic [2:0]      rxTimeToWait = 3'd0;
  logic            txStartTimer = 1'b0, txEnableTimer = 1'b0;
  logic [2:0]      txTimeToWait = 3'd0;
  logic            rxTimeOut, txTimeOut, busy, owner;
  logic [US_W-1:0] elapsedUs;

  int vectors = 0;
  int miscompares = 0;

  ltssm_timer_scheduler #(.TICKS_PER_US(T), .US_W(US_W)) dut (
    .clk(clk), .reset(reset),
    .rxStartTimer(rxStartTimer), .rxEnableTimer(rxEnableTimer), .rxTimeToWait(rxTimeToWait),
    .txStartTimer(txStartTimer), .txEnableTimer(txEnableTimer), .txTimeToWait(txTimeToWait),
    .rxTimeOut(rxTimeOut), .txTimeOut(txTimeOut), .busy(busy), .owner(owner),
    .elapsedUs(elapsedUs)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the timer, how many edges since the (re)start, what limit applies
  int   decTab [8] = '{0, 12000, 24000, 48000, 2000, 8000, 1000, 0};
  logic mBusy = 1'b0, mOwner = 1'b0, mLast = 1'b1, mPendRx = 1'b0, mPendTx = 1'b0;
  int   mK = 0, mLim = 0, mFrozen = 0;

  function automatic int modelElapsed(input logic b, input int k, input int lim, input int frozen);
    if (!b) return frozen;
    return (k / T < lim) ? k / T : lim;
  endfunction

  initial forever begin
    logic reqR, reqT, cR, cT, gR, gT, wasBusy, wasOwner;
    @(posedge clk or posedge reset);
    if (reset) begin
      mBusy = 0; mOwner = 0; mLast = 1; mPendRx = 0; mPendTx = 0;
      mK = 0; mLim = 0; mFrozen = 0;
    end else begin
      reqR = rxStartTimer & rxEnableTimer;
      reqT = txStartTimer & txEnableTimer;
      wasBusy = mBusy; wasOwner = mOwner;
      gR = 0; gT = 0;
      if (!mBusy) begin
        cR = rxEnableTimer & (rxStartTimer | mPendRx);
        cT = txEnableTimer & (txStartTimer | mPendTx);
        if (cR && cT) begin
          gR = mLast; gT = !mLast;
        end else begin
          gR = cR; gT = cT;
        end
        if (gR || gT) begin
          mBusy = 1; mOwner = gT; mLast = gT; mK = 0;
          mLim = decTab[gT ? txTimeToWait : rxTimeToWait];
        end
      end else if (!(mOwner ? txEnableTimer : rxEnableTimer)) begin
        mFrozen = modelElapsed(1'b1, mK, mLim, 0);
        mBusy = 0;
      end else if (mOwner ? reqT : reqR) begin
        mK = 0;
        mLim = decTab[mOwner ? txTimeToWait : rxTimeToWait];
      end else if (mK < mLim * T + 1) begin
        mK++;
      end
      mPendRx = rxEnableTimer & !gR & (mPendRx | (reqR & !(wasBusy && !wasOwner)));
      mPendTx = txEnableTimer & !gT & (mPendTx | (reqT & !(wasBusy && wasOwner)));
    end
  end

  // Every-cycle comparison against the model
  initial forever begin
    int  eEl;
    logic eRx, eTx, bad;
    @(negedge clk);
    if (!reset) begin
      eEl = modelElapsed(mBusy, mK, mLim, mFrozen);
      eRx = mBusy && !mOwner && (mK == mLim * T + 1);
      eTx = mBusy && mOwner && (mK == mLim * T + 1);
      bad = (busy !== mBusy) || (rxTimeOut !== eRx) || (txTimeOut !== eTx) ||
            (int'(elapsedUs) != eEl) || (mBusy && owner !== mOwner);
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL cycle t=%0t got busy=%b owner=%b rxTO=%b txTO=%b el=%0d expected busy=%b owner=%b rxTO=%b txTO=%b el=%0d",
                 $time, busy, owner, rxTimeOut, txTimeOut, elapsedUs, mBusy, mOwner, eRx, eTx, eEl);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Edges from the last grant/restart edge until the flag rises
  task automatic countToTimeout(input logic tx, output int n);
    n = 0;
    while (!(tx ? txTimeOut : rxTimeOut) && n < 20000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic waitElapsed(input int target);
    int n = 0;
    while (int'(elapsedUs) != target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("waitElapsed bound", int'(int'(elapsedUs) == target), 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    rxStartTimer = 0; rxEnableTimer = 0; txStartTimer = 0; txEnableTimer = 0;
    reset = 1;
    cyc(2);
    reset = 0;
  endtask

  initial begin
    int n;
    logic [2:0] code;
    logic sawTo;
    // Reset state
    #12;
    check("reset busy", busy, 0);
    check("reset owner", owner, 0);
    check("reset rxTimeOut", rxTimeOut, 0);
    check("reset elapsedUs", elapsedUs, 0);
    @(negedge clk);
    reset = 0;

    // 1: RX 1 ms
    @(negedge clk);
    rxStartTimer = 1; rxEnableTimer = 1; rxTimeToWait = 3'd6;
    @(negedge clk);
    rxStartTimer = 0;
    check("t1 busy", busy, 1);
    check("t1 owner", owner, 0);
    countToTimeout(1'b0, n);
    check("t1 latency", n, 4001);
    check("t1 txTimeOut", txTimeOut, 0);
    rxEnableTimer = 0;
    cyc(2);

    // 2: simultaneous start after reset, code 0
    doReset();
    rxStartTimer = 1; rxEnableTimer = 1; rxTimeToWait = 0;
    txStartTimer = 1; txEnableTimer = 1; txTimeToWait = 0;
    @(negedge clk);
    rxStartTimer = 0; txStartTimer = 0;
    check("t2 first owner", owner, 0);
    @(negedge clk);
    check("t2 rxTimeOut", rxTimeOut, 1);
    check("t2 txTimeOut idle side", txTimeOut, 0);
    rxEnableTimer = 0;
    @(negedge clk);
    check("t2 idle gap", busy, 0);
    @(negedge clk);
    check("t2 tx busy", busy, 1);
    check("t2 tx owner", owner, 1);
    @(negedge clk);
    check("t2 txTimeOut", txTimeOut, 1);
    txEnableTimer = 0;
    cyc(2);

    // 3: TX 2 ms aborted at 500 us
    txStartTimer = 1; txEnableTimer = 1; txTimeToWait = 3'd4;
    @(negedge clk);
    txStartTimer = 0;
    sawTo = 0;
    n = 0;
    while (int'(elapsedUs) != 500 && n < 5000) begin
      sawTo = sawTo | txTimeOut;
      @(negedge clk);
      n++;
    end
    check("t3 reached 500", elapsedUs, 500);
    txEnableTimer = 0;
    @(negedge clk);
    check("t3 aborted", busy, 0);
    check("t3 no timeout", int'(sawTo | txTimeOut), 0);
    txStartTimer = 1; txEnableTimer = 1; txTimeToWait = 3'd6;
    @(negedge clk);
    txStartTimer = 0;
    check("t3 regrant elapsed", elapsedUs, 0);
    txEnableTimer = 0;
    cyc(2);

    // 4: RX 48 ms restarted with 2 ms at 100 us
    rxStartTimer = 1; rxEnableTimer = 1; rxTimeToWait = 3'd3;
    @(negedge clk);
    rxStartTimer = 0;
    waitElapsed(100);
    rxStartTimer = 1; rxTimeToWait = 3'd4;
    @(negedge clk);
    rxStartTimer = 0;
    check("t4 restart elapsed", elapsedUs, 0);
    countToTimeout(1'b0, n);
    check("t4 latency", n, 8001);

    // 5: TX pending while RX in EXPIRED
    txStartTimer = 1; txEnableTimer = 1; txTimeToWait = 0;
    @(negedge clk);
    txStartTimer = 0;
    cyc(3);
    check("t5 rx keeps owner", owner, 0);
    rxEnableTimer = 0;
    @(negedge clk);
    check("t5 idle gap", busy, 0);
    @(negedge clk);
    check("t5 tx owner", owner, 1);
    check("t5 tx busy", busy, 1);
    txEnableTimer = 0;
    cyc(2);
    rxStartTimer = 1; rxEnableTimer = 1; rxTimeToWait = 0;
    @(negedge clk);
    rxStartTimer = 0;
    txStartTimer = 1; txEnableTimer = 1;
    @(negedge clk);
    txStartTimer = 0; txEnableTimer = 0;
    @(negedge clk);
    rxEnableTimer = 0;
    cyc(3);
    check("t5 dropped pending", busy, 0);

    // 6: asynchronous reset mid-RUN
    rxStartTimer = 1; rxEnableTimer = 1; rxTimeToWait = 3'd6;
    @(negedge clk);
    rxStartTimer = 0;
    cyc(50);
    #2 reset = 1;
    #1;
    check("t6 async busy", busy, 0);
    check("t6 async elapsed", elapsedUs, 0);
    check("t6 async rxTimeOut", rxTimeOut, 0);
    rxEnableTimer = 0;
    @(negedge clk);
    reset = 0;
    rxStartTimer = 1; rxEnableTimer = 1; rxTimeToWait = 0;
    txStartTimer = 1; txEnableTimer = 1; txTimeToWait = 0;
    @(negedge clk);
    rxStartTimer = 0; txStartTimer = 0;
    check("t6 rx first", owner, 0);
    rxEnableTimer = 0; txEnableTimer = 0;
    cyc(3);

    // Random traffic
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (rxEnableTimer) begin
        if ($urandom_range(1500) == 0) rxEnableTimer = 0;
      end else if ($urandom_range(40) == 0) rxEnableTimer = 1;
      if (txEnableTimer) begin
        if ($urandom_range(1500) == 0) txEnableTimer = 0;
      end else if ($urandom_range(40) == 0) txEnableTimer = 1;
      rxStartTimer = ($urandom_range(150) == 0);
      txStartTimer = ($urandom_range(150) == 0);
      code = 3'($urandom_range(7));
      if (code inside {3'd1, 3'd2, 3'd3} && $urandom_range(3) != 0) code = 3'd0;
      rxTimeToWait = code;
      code = 3'($urandom_range(7));
      if (code inside {3'd1, 3'd2, 3'd3} && $urandom_range(3) != 0) code = 3'd7;
      txTimeToWait = code;
    end
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
